// File: rtl/texture_pkg.sv
// Shared constants for the tile texture RAM: tile geometry, legal pixel depths
// and the clear-sequencer state encoding.
package texture_pkg;

   localparam int TILE_W = 8;
   localparam int TILE_H = 8;

   localparam int BPP_2 = 2;
   localparam int BPP_4 = 4;
   localparam int BPP_8 = 8;

   typedef enum logic {
      CLR_IDLE  = 1'b0,
      CLR_CLEAR = 1'b1
   } clr_state_t;

   function automatic bit bpp_legal(input int bpp);
      return (bpp == BPP_2) || (bpp == BPP_4) || (bpp == BPP_8);
   endfunction

   function automatic bit tile_count_legal(input int n);
      return (n >= 16) && (n <= 256) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/tile_texture_ram_if.sv
// Write / clear / pixel-read bundle of the tile texture RAM.
// Optional flip inputs are present only when TEXTURE_FLIP_EN is defined.
interface tile_texture_ram_if
   import texture_pkg::*;
#(
   parameter int TILE_COUNT = 64,
   parameter int BPP        = 4
);
   localparam int AW = $clog2(TILE_COUNT * TILE_W * BPP);
   localparam int TW = $clog2(TILE_COUNT);

   logic           wen;
   logic [AW-1:0]  waddr;
   logic [7:0]     wdata;
   logic           clear_start;
   logic           busy;
   logic           ren;
   logic [TW-1:0]  rtile;
   logic [2:0]     rx;
   logic [2:0]     ry;
   logic [BPP-1:0] rdata;
   logic           rvalid;
`ifdef TEXTURE_FLIP_EN
   logic           rhflip;
   logic           rvflip;

   modport master (
      output wen, waddr, wdata, clear_start, ren, rtile, rx, ry, rhflip, rvflip,
      input  busy, rdata, rvalid
   );
   modport slave (
      input  wen, waddr, wdata, clear_start, ren, rtile, rx, ry, rhflip, rvflip,
      output busy, rdata, rvalid
   );
`else
   modport master (
      output wen, waddr, wdata, clear_start, ren, rtile, rx, ry,
      input  busy, rdata, rvalid
   );
   modport slave (
      input  wen, waddr, wdata, clear_start, ren, rtile, rx, ry,
      output busy, rdata, rvalid
   );
`endif

endinterface

// File: rtl/texture_bram.sv
// Byte-wide simple dual-port RAM: one write port, one registered read port,
// no reset, so it maps onto iCE40 block RAM. Reads return the pre-write byte.
module texture_bram #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [0:(1 << AW) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/tile_texture_ram.sv
// Tile texture store: byte writes, 2-cycle pipelined pixel reads and a
// sequenced memory clear. Optional tile flipping via TEXTURE_FLIP_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// CLR_IDLE  | external writes pass to the RAM, clear_start is honoured
// CLR_CLEAR | RAM write port owned by the clear counter, one byte per cycle
module tile_texture_ram
   import texture_pkg::*;
#(
   parameter int TILE_COUNT = 64,
   parameter int BPP        = 4
) (
   input  logic               clk,
   input  logic               resetn,
   tile_texture_ram_if.slave  bus
);

   localparam int PPB   = 8 / BPP;
   localparam int DEPTH = TILE_COUNT * TILE_W * BPP;
   localparam int AW    = $clog2(DEPTH);
   localparam int PW    = $clog2(TILE_W * TILE_H);
   localparam int SH    = $clog2(PPB);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   if (!bpp_legal(BPP)) begin : g_bpp_err
      $error("tile_texture_ram: BPP must be 2, 4 or 8");
   end
   if (!tile_count_legal(TILE_COUNT)) begin : g_tile_err
      $error("tile_texture_ram: TILE_COUNT must be a power of two in 16..256");
   end

   clr_state_t    state, state_nx;
   logic [AW-1:0] clr_cnt, clr_cnt_nx;
   logic          clr_we;
   logic          busy_c;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= CLR_IDLE;
         clr_cnt <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= clr_cnt_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      clr_cnt_nx = clr_cnt;
      clr_we     = 1'b0;
      busy_c     = 1'b0;
      case (state)
         CLR_IDLE: begin
            if (bus.clear_start) begin
               state_nx   = CLR_CLEAR;
               clr_cnt_nx = '0;
            end
         end
         CLR_CLEAR: begin
            busy_c = 1'b1;
            clr_we = 1'b1;
            // Counter parks at zero on exit instead of wrapping past the last byte.
            if (clr_cnt == LAST_ADDR) begin
               state_nx   = CLR_IDLE;
               clr_cnt_nx = '0;
            end else begin
               clr_cnt_nx = clr_cnt + 1'b1;
            end
         end
         default: state_nx = CLR_IDLE;
      endcase
   end

   assign bus.busy = busy_c;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   always_comb begin
      wr_en   = bus.wen;
      wr_addr = bus.waddr;
      wr_data = bus.wdata;
      if (clr_we) begin
         wr_en   = 1'b1;
         wr_addr = clr_cnt;
         wr_data = 8'h00;
      end
   end

   logic [2:0]    col, row;
   logic [PW-1:0] pix;
   logic [AW-1:0] rd_addr;
   logic [2:0]    lane_off;

   always_comb begin
`ifdef TEXTURE_FLIP_EN
      col = bus.rhflip ? ~bus.rx : bus.rx;
      row = bus.rvflip ? ~bus.ry : bus.ry;
`else
      col = bus.rx;
      row = bus.ry;
`endif
      pix      = {row, col};
      rd_addr  = {bus.rtile, pix[PW-1:SH]};
      lane_off = 3'((int'(pix) % PPB) * BPP);
   end

   // The RAM is addressed straight from the request so its output register
   // doubles as stage 1; a same-cycle write therefore reads back the old byte.
   logic [7:0] byte_q;

   texture_bram #(.AW(AW)) u_bram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (bus.ren),
      .raddr (rd_addr),
      .rdata (byte_q)
   );

   logic           s1_valid;
   logic [2:0]     s1_off;
   logic [7:0]     pix_word;
   logic [BPP-1:0] rdata_q;
   logic           rvalid_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_off   <= '0;
      end else begin
         s1_valid <= bus.ren;
         if (bus.ren) begin
            s1_off <= lane_off;
         end
      end
   end

   assign pix_word = byte_q >> s1_off;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= s1_valid;
         if (s1_valid) begin
            rdata_q <= pix_word[BPP-1:0];
         end
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_tile_texture_ram.sv
// Directed bench for tile_texture_ram (TILE_COUNT=64, BPP=4) with a byte-level
// memory model feeding a read scoreboard. Flip steps run when TEXTURE_FLIP_EN is defined.
module tb_tile_texture_ram;

   localparam int TILE_COUNT = 64;
   localparam int BPP        = 4;
   localparam int DEPTH      = 2048;

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   tile_texture_ram_if #(.TILE_COUNT(TILE_COUNT), .BPP(BPP)) bus ();

   tile_texture_ram #(.TILE_COUNT(TILE_COUNT), .BPP(BPP)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic [3:0] val;
      int         cyc;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] model_mem [DEPTH];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   logic [3:0] hold_val = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_pix(input int t, input int x, input int y,
                                            input bit hf, input bit vf);
      int ex;
      int ey;
      int p;
      int b;
      logic [7:0] v;
      ex = hf ? 7 - x : x;
      ey = vf ? 7 - y : y;
      p  = ey * 8 + ex;
      b  = t * 8 * BPP + p / (8 / BPP);
      v  = model_mem[b];
      return 4'((v >> ((p % (8 / BPP)) * BPP)) & 8'h0F);
   endfunction

   // Read results are popped here; between results rdata must hold the last pixel.
   always @(negedge clk) begin
      if (resetn !== 1'b1) begin
         hold_val = '0;
      end else if (bus.rvalid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("rvalid_spurious", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("rdata", 32'(bus.rdata), 32'(e.val));
            chk("rvalid_latency", cyc, e.cyc);
            hold_val = e.val;
         end
      end else begin
         chk("rdata_hold", 32'(bus.rdata), 32'(hold_val));
      end
   end

   // One call = one clock cycle of stimulus, issued just after a rising edge.
   task automatic step(input bit we, input int wa, input int wd, input bit re,
                       input int t, input int x, input int y,
                       input bit hf, input bit vf, input bit cs);
      exp_t e;
      if (re) begin
         e.val = model_pix(t, x, y, hf, vf);
         e.cyc = cyc + 2;
         sbq.push_back(e);
      end
      if (we && bus.busy !== 1'b1) model_mem[wa] = 8'(wd);
      bus.wen         = we;
      bus.waddr       = 11'(wa);
      bus.wdata       = 8'(wd);
      bus.ren         = re;
      bus.rtile       = 6'(t);
      bus.rx          = 3'(x);
      bus.ry          = 3'(y);
      bus.clear_start = cs;
`ifdef TEXTURE_FLIP_EN
      bus.rhflip      = hf;
      bus.rvflip      = vf;
`endif
      @(posedge clk);
      #1;
      bus.wen         = 1'b0;
      bus.ren         = 1'b0;
      bus.clear_start = 1'b0;
`ifdef TEXTURE_FLIP_EN
      bus.rhflip      = 1'b0;
      bus.rvflip      = 1'b0;
`endif
   endtask

   task automatic wr(input int a, input int d);
      step(1'b1, a, d, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd(input int t, input int x, input int y);
      step(1'b0, 0, 0, 1'b1, t, x, y, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain(input string tag);
      idle(4);
      chk(tag, 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      resetn          = 1'b0;
      bus.wen         = 1'b0;
      bus.waddr       = '0;
      bus.wdata       = '0;
      bus.ren         = 1'b0;
      bus.rtile       = '0;
      bus.rx          = '0;
      bus.ry          = '0;
      bus.clear_start = 1'b0;
`ifdef TEXTURE_FLIP_EN
      bus.rhflip      = 1'b0;
      bus.rvflip      = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
      chk("reset_rdata", 32'(bus.rdata), 32'd0);
      resetn = 1'b1;
      idle(2);

      // Nibble order inside a byte
      wr('h000, 'hA5);
      rd(0, 0, 0);
      rd(0, 1, 0);
      drain("drain_basic");

      // Last pixel of tile 3, then four back-to-back reads
      wr('h07F, 'hC3);
      rd(3, 7, 7);
      rd(3, 7, 7);
      rd(3, 6, 7);
      rd(0, 1, 0);
      rd(0, 0, 0);
      drain("drain_b2b");

      // Same-cycle read and write of one byte
      step(1'b1, 'h000, 'h11, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      rd(0, 0, 0);
      drain("drain_rbw");

      // Full tile of random bytes, every pixel read back
      for (int b = 0; b < 32; b++) wr(5 * 32 + b, $urandom_range(0, 255));
      for (int p = 0; p < 64; p++) rd(5, p % 8, p / 8);
      drain("drain_tile5");

`ifdef TEXTURE_FLIP_EN
      wr('h003, 'hB0);
      step(1'b0, 0, 0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 0, 7, 7, 1'b1, 1'b1, 1'b0);
      step(1'b0, 0, 0, 1'b1, 0, 0, 7, 1'b0, 1'b1, 1'b0);
      step(1'b0, 0, 0, 1'b1, 3, 0, 0, 1'b1, 1'b1, 1'b0);
      drain("drain_flip");
`endif

      // Clear: dropped write and ignored restart mid-clear
      wr('h010, 'h5A);
      step(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (bus.busy === 1'b1 && n < 3000) begin
         if (n == 100) wr('h010, 'h77);
         else if (n == 200) step(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
         else idle(1);
         n++;
      end
      chk("clear_busy_cycles", n, DEPTH);
      chk("busy_after_clear", 32'(bus.busy), 32'd0);
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      rd(0, 0, 4);
      rd(0, 1, 4);
      for (int t = 0; t < TILE_COUNT; t++) rd(t, t % 8, (t / 8) % 8);
      rd(63, 7, 7);
      drain("drain_clear");

      // Reset with two reads in flight
      wr('h0A0, 'h9C);
      rd(5, 0, 0);
      drain("drain_prereset");
      bus.ren   = 1'b1;
      bus.rtile = 6'd5;
      bus.rx    = 3'd0;
      bus.ry    = 3'd0;
      @(posedge clk);
      #1;
      bus.rx = 3'd1;
      #2;
      resetn = 1'b0;
      #1;
      sbq.delete();
      chk("inreset_rvalid", 32'(bus.rvalid), 32'd0);
      chk("inreset_rdata", 32'(bus.rdata), 32'd0);
      chk("inreset_busy", 32'(bus.busy), 32'd0);
      bus.ren = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rvalid !== 1'b0) seen++;
      end
      chk("rvalid_after_reset", seen, 0);
      chk("rdata_after_reset", 32'(bus.rdata), 32'd0);
      @(posedge clk);
      #1;
      rd(5, 0, 0);
      rd(0, 0, 0);
      drain("drain_postreset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
